// File: rtl/acb_mem_arbiter.sv
// acb_mem_arbiter: round-robin share of the accelerator memory pipes with an in-order tag FIFO for response routing.
// Define ACB_ARB_FIXED_PRIO_EN to switch winner selection to lowest-index fixed priority.
module acb_mem_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     REQ_pipe_write_req,
    output logic [NUM_REQ-1:0]     REQ_pipe_write_ack,
    input  logic [NUM_REQ*110-1:0] REQ_pipe_write_data,
    output logic [64:0]            RESP_pipe_read_data,
    input  logic [NUM_REQ-1:0]     RESP_pipe_read_req,
    output logic [NUM_REQ-1:0]     RESP_pipe_read_ack,
    output logic [109:0]           ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data,
    input  logic                   ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req,
    output logic                   ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack,
    input  logic [64:0]            ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data,
    input  logic                   ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req,
    output logic                   ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int AW = $clog2(MAX_OUTSTANDING);
    localparam logic [AW:0] FULL = (AW+1)'(MAX_OUTSTANDING);

    logic               slot_valid;
    logic [109:0]       slot_data;
    logic [IW-1:0]      tags [MAX_OUTSTANDING];
    logic [AW-1:0]      wp, rp;
    logic [AW:0]        count;
    logic               resp_valid;
    logic [64:0]        resp_data;
    logic [IW-1:0]      resp_dest;
    logic [IW-1:0]      winner;
    logic               grant, resp_take, resp_consume;

`ifdef ACB_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (REQ_pipe_write_req[k]) winner = IW'(k);
    end
`else
    logic [IW-1:0] last_grant;
    // Descending scan so the requester nearest after last_grant is assigned last and wins.
    always_comb begin
        winner = '0;
        for (int k = NUM_REQ; k >= 1; k--)
            if (REQ_pipe_write_req[(int'(last_grant) + k) % NUM_REQ])
                winner = IW'((int'(last_grant) + k) % NUM_REQ);
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) last_grant <= IW'(NUM_REQ - 1);
        else if (grant) last_grant <= winner;
`endif

    assign grant = reset && (!slot_valid || ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req)
                   && (count != FULL) && (|REQ_pipe_write_req);

    always_comb begin
        REQ_pipe_write_ack         = '0;
        REQ_pipe_write_ack[winner] = grant;
    end

    assign resp_consume = resp_valid && RESP_pipe_read_req[resp_dest];
    assign ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack = (!resp_valid || resp_consume) && (count != '0);
    assign resp_take = ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack && ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            slot_valid <= 1'b0;
            slot_data  <= '0;
        end else if (grant) begin
            slot_valid <= 1'b1;
            slot_data  <= REQ_pipe_write_data[int'(winner)*110 +: 110];
        end else if (ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req) begin
            slot_valid <= 1'b0;
        end

    always_ff @(posedge clk)
        if (grant) tags[wp] <= winner;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (grant) wp <= wp + 1'b1;
            if (resp_take) rp <= rp + 1'b1;
            count <= count + (AW+1)'(grant) - (AW+1)'(resp_take);
        end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_dest  <= '0;
        end else if (resp_take) begin
            resp_valid <= 1'b1;
            resp_data  <= ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data;
            resp_dest  <= tags[rp];
        end else if (resp_consume) begin
            resp_valid <= 1'b0;
        end

    always_comb begin
        RESP_pipe_read_ack            = '0;
        RESP_pipe_read_ack[resp_dest] = resp_valid;
    end

    assign RESP_pipe_read_data                        = resp_data;
    assign ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack  = slot_valid;
    assign ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data = slot_data;
endmodule

// File: tb/tb_acb_mem_arbiter.sv
// tb_acb_mem_arbiter: randomized bench for acb_mem_arbiter against a queue-based reference model.
module tb_acb_mem_arbiter;
    localparam int N = 2;
    localparam int M = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [N-1:0]     wreq, wack, rreq, rack;
    logic [N*110-1:0] wdata;
    logic [64:0]      rdata, mdata_in;
    logic [109:0]     mreq_data;
    logic             mreq_rdy, mreq_ack, mresp_vld, mresp_ack;

    always #5 clk = ~clk;

    acb_mem_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(M)) dut (
        .clk(clk),
        .reset(reset),
        .REQ_pipe_write_req(wreq),
        .REQ_pipe_write_ack(wack),
        .REQ_pipe_write_data(wdata),
        .RESP_pipe_read_data(rdata),
        .RESP_pipe_read_req(rreq),
        .RESP_pipe_read_ack(rack),
        .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data(mreq_data),
        .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req(mreq_rdy),
        .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack(mreq_ack),
        .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data(mdata_in),
        .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req(mresp_vld),
        .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack(mresp_ack)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    typedef struct {
        int          dest;
        logic [64:0] data;
    } resp_t;

    logic [109:0] slot_q[$];
    int           tq[$];
    resp_t        resp_q[$];
    int           last = N - 1;

    task automatic drive(input int pw, input int pm, input int pr, input int pv);
        logic [127:0] r;
        for (int i = 0; i < N; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            wreq[i] = ($urandom_range(99) < pw);
            wdata[110*i +: 110] = r[109:0];
            rreq[i] = ($urandom_range(99) < pr);
        end
        r = {$urandom, $urandom, $urandom, $urandom};
        mdata_in  = r[64:0];
        mreq_rdy  = ($urandom_range(99) < pm);
        mresp_vld = ($urandom_range(99) < pv);
    endtask

    task automatic step();
        logic [N-1:0] ew, er;
        int           win;
        bit           cons, rfree, rtx, mtx;
        ew  = '0;
        er  = '0;
        win = -1;
        #1;
        if ((slot_q.size() == 0 || mreq_rdy) && tq.size() < M)
            for (int k = 1; k <= N; k++)
                if (win < 0 && wreq[(last + k) % N]) win = (last + k) % N;
        if (win >= 0) ew[win] = 1'b1;
        check("write_ack", wack, ew);
        check("mem_req_ack", mreq_ack, slot_q.size() != 0);
        if (slot_q.size() != 0) check("mem_req_data", mreq_data, slot_q[0]);
        cons  = resp_q.size() != 0 && rreq[resp_q[0].dest];
        rfree = resp_q.size() == 0 || cons;
        check("mem_resp_ack", mresp_ack, rfree && tq.size() > 0);
        if (resp_q.size() != 0) begin
            er[resp_q[0].dest] = 1'b1;
            check("resp_data", rdata, resp_q[0].data);
        end
        check("resp_ack", rack, er);
        rtx = mresp_vld && rfree && tq.size() > 0;
        mtx = mreq_rdy && slot_q.size() != 0;
        @(posedge clk);
        if (mtx) void'(slot_q.pop_front());
        if (cons) void'(resp_q.pop_front());
        if (rtx) resp_q.push_back('{tq.pop_front(), mdata_in});
        if (win >= 0) begin
            slot_q.push_back(wdata[110*win +: 110]);
            tq.push_back(win);
            last = win;
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        #1;
        check("rst_write_ack", wack, 0);
        check("rst_resp_ack", rack, 0);
        check("rst_resp_data", rdata, 0);
        check("rst_mem_req_ack", mreq_ack, 0);
        check("rst_mem_req_data", mreq_data, 0);
        check("rst_mem_resp_ack", mresp_ack, 0);
    endtask

    initial begin
        wreq = '0; rreq = '0; wdata = '0; mdata_in = '0;
        mreq_rdy = 1'b0; mresp_vld = 1'b0;
        @(negedge clk);
        wreq = '1; rreq = '1; mreq_rdy = 1'b1; mresp_vld = 1'b1;
        check_reset_outputs();
        @(negedge clk);
        reset = 1'b1;
        wreq = 2'b01; wdata = '0; wdata[109:0] = 110'h1234; mreq_rdy = 1'b1;
        mresp_vld = 1'b0; rreq = '1;
        step();
        wreq = '0;
        step();
        mresp_vld = 1'b1; mdata_in = 65'h0_DEADBEEF;
        step();
        mresp_vld = 1'b0;
        step();
        repeat (600) begin drive(60, 70, 70, 50); step(); end
        repeat (30) begin drive(100, 100, 70, 0); step(); end
        repeat (600) begin drive(60, 70, 70, 50); step(); end
        repeat (20) begin drive(50, 70, 0, 100); step(); end
        repeat (200) begin drive(80, 90, 50, 60); step(); end
        reset = 1'b0;
        wreq = '1; rreq = '1; mreq_rdy = 1'b1; mresp_vld = 1'b1;
        repeat (3) begin
            check_reset_outputs();
            @(negedge clk);
        end
        slot_q.delete();
        tq.delete();
        resp_q.delete();
        last = N - 1;
        reset = 1'b1;
        drive(50, 50, 50, 50);
        wreq = '1;
        step();
        repeat (500) begin drive(60, 70, 70, 50); step(); end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
